// File: rtl/gat_pkg.sv
// ---------------------------------------------------------------------------
// gat_pkg : shared types and constants for the GAT BRAM readout blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gat_pkg;

  localparam int NEW_FEATURE_WIDTH = 32;
  localparam int BRAM_LATENCY      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                         last;
    logic [NEW_FEATURE_WIDTH-1:0] data;
  } feat_entry_t;

endpackage

`default_nettype wire

// File: rtl/gat_feat_reader_if.sv
// ---------------------------------------------------------------------------
// gat_feat_reader_if : valid/ready feature stream with master/slave views
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gat_feat_reader_if #(
  parameter int W = gat_pkg::NEW_FEATURE_WIDTH
);
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

`default_nettype wire

// File: rtl/gat_sync_fifo.sv
// ---------------------------------------------------------------------------
// gat_sync_fifo : single-clock FIFO with full/empty/count, async reset
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gat_sync_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (count_q != CNT_W'(DEPTH));
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/gat_feat_reader.sv
// ---------------------------------------------------------------------------
// gat_feat_reader : sweeps the new-feature BRAM and streams it out valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gat_feat_reader
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_LATENCY       = gat_pkg::BRAM_LATENCY,
  parameter int FIFO_DEPTH         = BRAM_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  gat_feat_reader_if.master             m_axis
);

  localparam int IF_W  = $clog2(BRAM_LATENCY + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2);
  localparam int ROW_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [ROW_W-1:0]              ROW_LAST  = ROW_W'(NUM_FEATURE_OUT - 1);

  state_t                        state_q, state_d;
  logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [BRAM_LATENCY-1:0]       vld_q, vld_d;
  logic [BRAM_LATENCY-1:0]       tag_q, tag_d;

  logic              issue, pop, push;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [IF_W-1:0]   inflight;
  logic [CR_W-1:0]   credit_used;
  feat_entry_t       wr_entry, rd_entry;

  // Credit = post-pop occupancy plus reads still travelling through the BRAM.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + IF_W'(vld_q[i]);
    end
    pop         = !fifo_empty && m_axis.m_tready;
    credit_used = CR_W'(fifo_count) - CR_W'(pop) + CR_W'(inflight);
    issue       = (state_q == READ) && (credit_used < CR_W'(FIFO_DEPTH))
                  && !(fifo_full && !pop);
    push        = vld_q[BRAM_LATENCY-1];
  end

  always_comb begin
    vld_d[0] = issue;
    tag_d[0] = issue && (row_q == ROW_LAST);
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          row_d   = '0;
        end
      end
      READ: begin
        if (issue) begin
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && (fifo_count == CNT_W'(1)) && (inflight == '0)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.last = tag_q[BRAM_LATENCY-1];
    wr_entry.data = feat_bram_dout;
  end

  gat_sync_fifo #(
    .WIDTH ($bits(feat_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy            = (state_q == READ) || (state_q == DRAIN);
  assign done            = (state_q == DONE);
  assign feat_bram_enb   = issue;
  assign feat_bram_addrb = addr_q;

  // Head is masked while empty so idle outputs read as zero.
  assign m_axis.m_tvalid = !fifo_empty;
  assign m_axis.m_tdata  = fifo_empty ? '0 : rd_entry.data;
  assign m_axis.m_tlast  = !fifo_empty && rd_entry.last;

endmodule

`default_nettype wire

// File: tb/tb_gat_feat_reader.sv
// ---------------------------------------------------------------------------
// tb_gat_feat_reader : directed bench for gat_feat_reader (small + default size)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gat_feat_reader;

  localparam int AW  = 4;   // 12 words
  localparam int DAW = 16;  // 43328 words

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_d = 1'b0;
  always #5 clk = ~clk;

  gat_feat_reader_if #(.W(32)) s_if ();
  gat_feat_reader_if #(.W(32)) d_if ();

  logic           busy, done, enb;
  logic [AW-1:0]  addr, p1, p2;
  logic [31:0]    dout;
  logic           busy_d, done_d, enb_d;
  logic [DAW-1:0] addr_d, q1, q2;
  logic [31:0]    dout_d;

  gat_feat_reader #(.NUM_SUBGRAPHS(3), .NUM_FEATURE_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .feat_bram_enb(enb), .feat_bram_addrb(addr), .feat_bram_dout(dout),
    .m_axis(s_if)
  );

  gat_feat_reader dut_def (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d),
    .feat_bram_enb(enb_d), .feat_bram_addrb(addr_d), .feat_bram_dout(dout_d),
    .m_axis(d_if)
  );

  // Two-cycle BRAM: dout = 3*addr+1
  always @(posedge clk) begin
    if (enb) p1 <= addr;
    p2 <= p1;
    if (enb_d) q1 <= addr_d;
    q2 <= q1;
  end
  assign dout   = (32'(p2) * 32'd3) + 32'd1;
  assign dout_d = (32'(q2) * 32'd3) + 32'd1;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, first_v, done_cyc, last_beat_cyc;
  int enb_cnt, enb_early, done_cnt, addr_err, stab_err, busy_err;
  logic busy_s1;
  logic prev_stall;
  logic [31:0] prev_data;
  logic prev_last;
  logic [31:0] got_data[$];
  logic        got_last[$];
  int beats_d, lasts_d, done_d_cnt;
  logic [DAW-1:0] last_addr_d;
  beat_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    got_data.delete();
    got_last.delete();
    first_v = -1; done_cyc = -1; last_beat_cyc = -1;
    enb_cnt = 0; enb_early = 0; done_cnt = 0;
    addr_err = 0; stab_err = 0; busy_err = 0;
    busy_s1 = 1'b0; prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample everything mid-cycle, advance.
  task automatic tick(input logic rdy, input logic st);
    s_if.m_tready = rdy;
    start = st;
    #1;
    if (prev_stall && (!s_if.m_tvalid || s_if.m_tdata != prev_data || s_if.m_tlast != prev_last))
      stab_err++;
    if (s_if.m_tvalid && first_v < 0) first_v = cyc;
    if (s_if.m_tvalid && rdy) begin
      got_data.push_back(s_if.m_tdata);
      got_last.push_back(s_if.m_tlast);
      last_beat_cyc = cyc;
    end
    prev_stall = s_if.m_tvalid && !rdy;
    prev_data  = s_if.m_tdata;
    prev_last  = s_if.m_tlast;
    if (enb) begin
      if (enb_cnt > 11 || {28'd0, addr} != 32'(enb_cnt)) addr_err++;
      enb_cnt++;
      if (cyc - start_cyc <= 20) enb_early++;
    end
    if (cyc == start_cyc + 1) busy_s1 = busy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_err++;
    end
    if (enb_d) last_addr_d = addr_d;
    if (d_if.m_tvalid) beats_d++;
    if (d_if.m_tvalid && d_if.m_tlast) lasts_d++;
    if (done_d) done_d_cnt++;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic pick_rdy(input int mode, input int i);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (i <= 20) ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  // mode 0: ready high; 1: random ready; 2: ready low 20 cycles; 3: re-pulse start
  task automatic sweep(input int mode, input int budget);
    int i;
    clear_counts();
    start_cyc = cyc;
    tick(pick_rdy(mode, 0), 1'b1);
    i = 1;
    while (done_cnt == 0 && i < budget) begin
      tick(pick_rdy(mode, i), (mode == 3) && (i == 3 || i == 7));
      i++;
    end
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    check("sweep_done_seen", done_cnt, 1);
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_beats"}, got_data.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), int'(got_data[i]), int'(tbl[i].data));
        check($sformatf("%s_last%0d", tag, i), int'(got_last[i]), int'(tbl[i].last));
      end
    end
    check({tag, "_enb_count"}, enb_cnt, 12);
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_enb"}, int'(enb), 0);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_tvalid"}, int'(s_if.m_tvalid), 0);
    check({tag, "_tlast"}, int'(s_if.m_tlast), 0);
    check({tag, "_tdata"}, int'(s_if.m_tdata), 0);
  endtask

  initial begin
    tbl = '{'{32'd1, 1'b0},  '{32'd4, 1'b0},  '{32'd7, 1'b0},  '{32'd10, 1'b1},
            '{32'd13, 1'b0}, '{32'd16, 1'b0}, '{32'd19, 1'b0}, '{32'd22, 1'b1},
            '{32'd25, 1'b0}, '{32'd28, 1'b0}, '{32'd31, 1'b0}, '{32'd34, 1'b1}};
    d_if.m_tready = 1'b1;
    s_if.m_tready = 1'b0;
    beats_d = 0; lasts_d = 0; done_d_cnt = 0; last_addr_d = '0;
    start_cyc = -100;
    clear_counts();
    @(negedge clk);
    cyc = 0;

    #1;
    check_idle_outputs("reset");
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
    while (cyc < 10) tick(1'b1, 1'b0);

    // continuous ready, start at cycle 10
    sweep(0, 100);
    check_beats("cont");
    check("cont_first_valid_cyc", first_v, 14);
    check("cont_last_beat_cyc", last_beat_cyc, 25);
    check("cont_done_cyc", done_cyc, 26);
    check("cont_busy_after_start", int'(busy_s1), 1);
    check("cont_busy_low_at_done", busy_err, 0);

    // random backpressure
    sweep(1, 400);
    check_beats("rand");

    // ready held low for 20 cycles
    sweep(2, 200);
    check("stall_enb_pulses", enb_early, 4);
    check_beats("stall");

    // start re-pulsed mid-sweep
    sweep(3, 100);
    check_beats("restart");

    // reset after 5 accepted beats
    clear_counts();
    start_cyc = cyc;
    tick(1'b1, 1'b1);
    for (int k = 0; k < 40 && got_data.size() < 5; k++) tick(1'b1, 1'b0);
    check("rst_pre_beats", got_data.size(), 5);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    tick(1'b1, 1'b0);
    sweep(0, 100);
    check_beats("afterrst");

    // default parameters, full size
    beats_d = 0; lasts_d = 0; done_d_cnt = 0;
    start_d = 1'b1;
    tick(1'b1, 1'b0);
    start_d = 1'b0;
    for (int k = 0; k < 44000 && done_d_cnt == 0; k++) tick(1'b1, 1'b0);
    check("def_done_seen", done_d_cnt, 1);
    check("def_beats", beats_d, 43328);
    check("def_tlasts", lasts_d, 2708);
    check("def_final_addr", int'(last_addr_d), 43327);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
